// File: rtl/pipeline_sequencer_if.sv
//==============================================================================
// pipeline_sequencer_if : hazard inputs and latch-control outputs of the
// pipeline sequencer.  Rev 1.0
//==============================================================================
`default_nettype none

interface pipeline_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             dREN_mem;
    logic             dWEN_mem;
    logic             halt_mem;
    logic             PCsrc_mem;
    logic             idex_dREN;
    logic [4:0]       idex_wsel;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halt_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt;

    // The sequencer is the master: it consumes hazards and drives latch controls.
    modport master (
        input  ihit, dhit, dREN_mem, dWEN_mem, halt_mem, PCsrc_mem,
               idex_dREN, idex_wsel, ifid_rs, ifid_rt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt_o, err_o, stall_cnt
    );

    modport slave (
        output ihit, dhit, dREN_mem, dWEN_mem, halt_mem, PCsrc_mem,
               idex_dREN, idex_wsel, ifid_rs, ifid_rt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt_o, err_o, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
//==============================================================================
// pipeline_sequencer : stall/flush sequencer for the 5-stage pipeline with a
// data-wait watchdog and saturating stall counter.  Rev 1.0
//==============================================================================
`default_nettype none

module pipeline_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  nRST,
    pipeline_sequencer_if.master  bus
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  STALL_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DWAIT = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              halt_q, halt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic dreq;
    logic lu;
    logic pc_en;
    logic ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush;

    assign dreq = bus.dREN_mem | bus.dWEN_mem;
    assign lu   = bus.idex_dREN && (bus.idex_wsel != 5'd0) &&
                  ((bus.idex_wsel == bus.ifid_rs) || (bus.idex_wsel == bus.ifid_rt));

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            halt_q      <= halt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        halt_d      = halt_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_RUN: begin
                if (dreq && !bus.dhit) begin
                    state_d    = S_DWAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (!dreq && bus.halt_mem) begin
                    state_d = S_HALT;
                    halt_d  = 1'b1;
                end
            end
            S_DWAIT: begin
                if (bus.dhit) begin
                    state_d = S_RUN;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
        // Watchdog fires as the wait count reaches TIMEOUT.
        if (state_q == S_DWAIT && wait_cnt_d == WAIT_MAX) begin
            err_d = 1'b1;
        end
        if (!pc_en && state_q != S_HALT && stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Output logic
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        case (state_q)
            S_RUN: begin
                if (dreq && !bus.dhit) begin
                    pc_en = 1'b0;
                end else if (dreq) begin
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    ifid_flush = 1'b1;
                end else if (bus.halt_mem) begin
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (bus.PCsrc_mem) begin
                    pc_en       = 1'b1;
                    memwb_en    = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (lu) begin
                    // IF/ID holds even when the fetch is still outstanding.
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_flush = 1'b1;
                end else if (!bus.ihit) begin
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
            end
            S_DWAIT: begin
                if (bus.dhit) begin
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    ifid_flush = 1'b1;
                end
            end
            default: pc_en = 1'b0;
        endcase
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_flush = 1'b0;
    assign bus.halt_o      = halt_q;
    assign bus.err_o       = err_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
//==============================================================================
// tb_pipeline_sequencer : directed scoreboard bench for pipeline_sequencer.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_pipeline_sequencer;

    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 4;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //  ifid_flush, idex_flush, exmem_flush, memwb_flush}
    localparam logic [8:0] RUN_OK = 9'b1_1111_0000;
    localparam logic [8:0] FROZEN = 9'b0_0000_0000;
    localparam logic [8:0] DHIT   = 9'b0_0111_1000;
    localparam logic [8:0] NOIH   = 9'b0_0111_1000;
    localparam logic [8:0] HALTC  = 9'b0_0001_1110;
    localparam logic [8:0] BR     = 9'b1_0001_1110;
    localparam logic [8:0] LU     = 9'b0_0011_0100;

    // {ihit, dhit, dREN_mem, dWEN_mem, halt_mem, PCsrc_mem, idex_dREN}
    localparam logic [6:0] IN_N    = 7'b1000000;
    localparam logic [6:0] IN_MISS = 7'b1010000;

    typedef struct {
        string      tag;
        logic [8:0] ctl;
        logic       halt;
        logic       err;
        int         cnt;
    } exp_t;

    logic CLK;
    logic nRST;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    pipeline_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pipeline_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v, input logic [4:0] w, input logic [4:0] rs,
                         input logic [4:0] rt);
        {bus.ihit, bus.dhit, bus.dREN_mem, bus.dWEN_mem,
         bus.halt_mem, bus.PCsrc_mem, bus.idex_dREN} = v;
        bus.idex_wsel = w;
        bus.ifid_rs   = rs;
        bus.ifid_rt   = rt;
    endtask

    task automatic push_exp(input string tag, input logic [8:0] ctl, input logic h,
                            input logic e, input int cnt);
        exp_t x;
        x.tag = tag; x.ctl = ctl; x.halt = h; x.err = e; x.cnt = cnt;
        sb.push_back(x);
    endtask

    task automatic compare_head();
        exp_t       x;
        logic [8:0] ctl_obs;
        logic [3:0] en_obs;
        logic [3:0] fl_obs;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(1), 32'(0));
            return;
        end
        x       = sb.pop_front();
        ctl_obs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
        en_obs  = ctl_obs[7:4];
        fl_obs  = ctl_obs[3:0];
        chk({x.tag, "_ctl"},   32'(ctl_obs),       32'(x.ctl));
        chk({x.tag, "_halt"},  32'(bus.halt_o),    32'(x.halt));
        chk({x.tag, "_err"},   32'(bus.err_o),     32'(x.err));
        chk({x.tag, "_stall"}, 32'(bus.stall_cnt), 32'(x.cnt));
        chk({x.tag, "_enfl"},  32'(en_obs & fl_obs), 32'(0));
    endtask

    // One pipeline cycle: drive at posedge+1, compare at the following negedge.
    task automatic step(input string tag, input logic [6:0] v, input logic [4:0] w,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [8:0] ctl,
                        input logic h, input logic e, input int cnt);
        drive(v, w, rs, rt);
        push_exp(tag, ctl, h, e, cnt);
        @(negedge CLK);
        compare_head();
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset between clock edges; registers must clear immediately.
    task automatic pulse_reset(input string tag);
        drive(IN_N, 5'd0, 5'd0, 5'd0);
        nRST = 1'b0;
        #2;
        push_exp(tag, RUN_OK, 1'b0, 1'b0, 0);
        compare_head();
        #4;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(IN_N, 5'd0, 5'd0, 5'd0);
        #12;
        push_exp("reset", RUN_OK, 1'b0, 1'b0, 0);
        compare_head();
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        step("run0", IN_N, 5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 0);
        step("run1", IN_N, 5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 0);
        step("run2", IN_N, 5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 0);

        // Load miss: three frozen cycles, then the dhit cycle.
        step("miss0", IN_MISS,    5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b0, 0);
        step("miss1", IN_MISS,    5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b0, 1);
        step("miss2", IN_MISS,    5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b0, 2);
        step("dhitw", 7'b1110000, 5'd0, 5'd0, 5'd0, DHIT,   1'b0, 1'b0, 3);
        step("back",  IN_N,       5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 4);
        step("dhitr", 7'b1110000, 5'd0, 5'd0, 5'd0, DHIT,   1'b0, 1'b0, 4);
        step("run3",  IN_N,       5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 5);

        // Load-use hazards and the r0 exception.
        step("lu_rt",   7'b1000001, 5'd5, 5'd0, 5'd5, LU,     1'b0, 1'b0, 5);
        step("run4",    IN_N,       5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 6);
        step("lu_r0",   7'b1000001, 5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 6);
        step("lu_rs_nh",7'b0000001, 5'd3, 5'd3, 5'd9, LU,     1'b0, 1'b0, 6);
        step("run5",    IN_N,       5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 7);
        step("noihit",  7'b0000000, 5'd0, 5'd0, 5'd0, NOIH,   1'b0, 1'b0, 7);
        step("run6",    IN_N,       5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 8);

        // Taken branch beats load-use and a missing fetch.
        step("br_lu",   7'b1000011, 5'd5, 5'd0, 5'd5, BR,     1'b0, 1'b0, 8);
        step("run7",    IN_N,       5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 8);
        step("br_nih",  7'b0000010, 5'd0, 5'd0, 5'd0, BR,     1'b0, 1'b0, 8);

        // Store miss long enough to trip the watchdog.
        step("to0", 7'b1001000, 5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b0, 8);
        step("to1", 7'b1001000, 5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b0, 9);
        step("to2", 7'b1001000, 5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b0, 10);
        step("to3", 7'b1001000, 5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b0, 11);
        step("to4", 7'b1001000, 5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b1, 12);
        step("to5", 7'b1001000, 5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b1, 13);
        step("to_dhit", 7'b1101000, 5'd0, 5'd0, 5'd0, DHIT, 1'b0, 1'b1, 14);
        step("to_run",  IN_N,       5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b1, 15);

        // Stall counter saturation at 2^CNT_W-1.
        for (int i = 0; i < 20; i++) begin
            step("sat", 7'b0000000, 5'd0, 5'd0, 5'd0, NOIH, 1'b0, 1'b1,
                 (15 + i > 31) ? 31 : 15 + i);
        end
        step("sat_hold", IN_N, 5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b1, 31);

        pulse_reset("rst_run");

        // Halt wins over a simultaneous branch and is permanent.
        step("halt",  7'b1000110, 5'd0, 5'd0, 5'd0, HALTC,  1'b0, 1'b0, 0);
        step("hlt0",  IN_MISS,    5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 1'b0, 1);
        step("hlt1",  IN_N,       5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 1'b0, 1);
        step("hlt2",  7'b1000010, 5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 1'b0, 1);
        pulse_reset("rst_halt");
        step("post_halt", IN_N, 5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 0);

        // Reset while waiting on data.
        step("dw0", IN_MISS, 5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b0, 0);
        step("dw1", IN_MISS, 5'd0, 5'd0, 5'd0, FROZEN, 1'b0, 1'b0, 1);
        pulse_reset("rst_dwait");
        step("post_dw", IN_N, 5'd0, 5'd0, 5'd0, RUN_OK, 1'b0, 1'b0, 0);

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
